// File: rtl/baud_gen_frac.sv
// Fractional-divisor baud tick generator: oversample tick every DIV_INT + DIV_FRAC/2^FRAC_W cycles, bit strobe every OVS ticks.
// Define BAUD_FRAC_EN to build the fractional phase accumulator; without it every interval is exactly the integer divisor.
module baud_gen_frac #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned FRAC_W   = 4,
  parameter int unsigned OVS      = 16,
  parameter int unsigned DEF_INT  = 54,
  parameter int unsigned DEF_FRAC = 4
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic              en,
  input  logic              div_wr,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick,
  output logic              bit_tick,
  output logic              upd_pending
);

  localparam int unsigned OVS_W = (OVS > 2) ? $clog2(OVS) : 1;
  localparam int unsigned LIM_W = CNT_W + 1;

  if (DEF_INT < 2) begin : g_def_int_chk
    $error("baud_gen_frac: DEF_INT must be at least 2");
  end
  if (OVS < 2) begin : g_ovs_chk
    $error("baud_gen_frac: OVS must be at least 2");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_int;
  logic [CNT_W-1:0] pend_int;
  logic [OVS_W-1:0] ovs_cnt;
  logic             extra_c;
  logic [LIM_W-1:0] limit_c;
  logic             boundary_c;
  logic             apply_c;
  logic             ovs_last_c;
  logic [CNT_W-1:0] div_int_clamped_c;

  // The limit is one bit wider than cnt so act_int - 1 + extra cannot wrap.
  assign limit_c           = LIM_W'(act_int) - LIM_W'(1) + LIM_W'(extra_c);
  assign boundary_c        = en && (LIM_W'(cnt) >= limit_c);
  assign apply_c           = upd_pending && (boundary_c || !en);
  assign ovs_last_c        = (ovs_cnt == OVS_W'(OVS - 1));
  assign div_int_clamped_c = (div_int < CNT_W'(2)) ? CNT_W'(2) : div_int;

  // Interval counter, tick outputs and divisor capture/apply
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt         <= '0;
      ovs_cnt     <= '0;
      act_int     <= CNT_W'(DEF_INT);
      pend_int    <= '0;
      upd_pending <= 1'b0;
      tick        <= 1'b0;
      bit_tick    <= 1'b0;
    end else begin
      if (en) begin
        if (boundary_c) begin
          cnt      <= '0;
          tick     <= 1'b1;
          bit_tick <= ovs_last_c;
          ovs_cnt  <= ovs_last_c ? '0 : ovs_cnt + OVS_W'(1);
        end else begin
          cnt      <= cnt + CNT_W'(1);
          tick     <= 1'b0;
          bit_tick <= 1'b0;
        end
      end else begin
        tick     <= 1'b0;
        bit_tick <= 1'b0;
      end
      if (apply_c) begin
        act_int     <= pend_int;
        upd_pending <= 1'b0;
      end
      // A write in the same cycle as an apply re-arms with the new value.
      if (div_wr) begin
        pend_int    <= div_int_clamped_c;
        upd_pending <= 1'b1;
      end
    end
  end

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] pend_frac;
  logic              extra;
  logic [FRAC_W:0]   acc_sum_c;

  assign acc_sum_c = (FRAC_W + 1)'(acc) + (FRAC_W + 1)'(act_frac);
  assign extra_c   = extra;

  // Phase accumulator: the carry stretches the following interval by one cycle
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      acc       <= '0;
      extra     <= 1'b0;
      act_frac  <= FRAC_W'(DEF_FRAC);
      pend_frac <= '0;
    end else begin
      if (boundary_c) begin
        {extra, acc} <= acc_sum_c;
      end
      if (apply_c) begin
        acc      <= '0;
        extra    <= 1'b0;
        act_frac <= pend_frac;
      end
      if (div_wr) begin
        pend_frac <= div_frac;
      end
    end
  end
`else
  logic unused_frac;

  assign extra_c     = 1'b0;
  assign unused_frac = ^{div_frac, FRAC_W'(DEF_FRAC)};
`endif

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed scenarios plus random traffic against an interval-level reference model.
// Honours BAUD_FRAC_EN the same way as the design build.
module tb_baud_gen_frac;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned FRAC_W   = 4;
  localparam int unsigned OVS      = 16;
  localparam int unsigned DEF_INT  = 54;
  localparam int unsigned DEF_FRAC = 4;

  logic              clk_100MHz = 1'b0;
  logic              reset      = 1'b1;
  logic              en         = 1'b0;
  logic              div_wr     = 1'b0;
  logic [CNT_W-1:0]  div_int    = '0;
  logic [FRAC_W-1:0] div_frac   = '0;
  logic              tick;
  logic              bit_tick;
  logic              upd_pending;

  baud_gen_frac #(
    .CNT_W   (CNT_W),
    .FRAC_W  (FRAC_W),
    .OVS     (OVS),
    .DEF_INT (DEF_INT),
    .DEF_FRAC(DEF_FRAC)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .en         (en),
    .div_wr     (div_wr),
    .div_int    (div_int),
    .div_frac   (div_frac),
    .tick       (tick),
    .bit_tick   (bit_tick),
    .upd_pending(upd_pending)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed enabled cycles in the current interval and
  // the interval index since the divisor was last loaded.
  int m_elapsed, m_idx, m_int, m_frac, m_pint, m_pfrac, m_ticks;
  bit m_pend, m_tick, m_bit;

  int n;
  int last_tick;
  int intervals[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Extra cycle owed to interval j: carries of the running phase j*frac/2^FRAC_W.
  function automatic int extra_of(input int j, input int f);
`ifdef BAUD_FRAC_EN
    if (j == 0) return 0;
    return (j * f) / (1 << FRAC_W) - ((j - 1) * f) / (1 << FRAC_W);
`else
    return 0;
`endif
  endfunction

  task automatic model_step(input bit r, input bit e, input bit w, input int di, input int df);
    int  len;
    bit  bnd;
    bit  app;
    if (r) begin
      m_elapsed = 0; m_idx = 0; m_int = DEF_INT; m_frac = DEF_FRAC;
      m_pint = 0; m_pfrac = 0; m_pend = 0; m_tick = 0; m_bit = 0; m_ticks = 0;
      return;
    end
    len = m_int + extra_of(m_idx, m_frac);
    bnd = e && (m_elapsed >= len - 1);
    app = m_pend && (bnd || !e);
    m_tick = bnd;
    m_bit  = bnd && ((m_ticks % OVS) == OVS - 1);
    if (bnd) begin
      m_elapsed = 0;
      m_idx++;
      m_ticks++;
    end else if (e) begin
      m_elapsed++;
    end
    if (app) begin
      m_int = m_pint; m_frac = m_pfrac; m_idx = 0; m_pend = 0;
    end
    if (w) begin
      m_pint  = (di < 2) ? 2 : di;
      m_pfrac = df;
      m_pend  = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit w, input int di, input int df);
    reset    = r;
    en       = e;
    div_wr   = w;
    div_int  = CNT_W'(di);
    div_frac = FRAC_W'(df);
    model_step(r, e, w, di, df);
    @(posedge clk_100MHz);
    #1;
    n++;
    check("tick", 32'(tick), 32'(m_tick));
    check("bit_tick", 32'(bit_tick), 32'(m_bit));
    check("upd_pending", 32'(upd_pending), 32'(m_pend));
    if (tick === 1'b1) begin
      intervals.push_back(n - last_tick);
      last_tick = n;
    end
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0);
    n = 0;
    last_tick = 0;
    intervals.delete();
  endtask

  task automatic run(input int cycles, input bit e);
    for (int i = 0; i < cycles; i++) cyc(0, e, 0, 0, 0);
  endtask

  task automatic check_last_interval(input string tag, input int exp);
    check({tag, "_seen"}, 32'(intervals.size() > 0), 32'd1);
    if (intervals.size() > 0) check(tag, 32'(intervals[intervals.size() - 1]), 32'(exp));
  endtask

  int exp_iv[9];
  int sum;

  initial begin
    n = 0;
    last_tick = 0;
`ifdef BAUD_FRAC_EN
    exp_iv = '{54, 54, 54, 54, 55, 54, 54, 54, 55};
`else
    exp_iv = '{54, 54, 54, 54, 54, 54, 54, 54, 54};
`endif

    // Reset defaults and the default 54.25 cadence
    do_reset();
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_bit_tick", 32'(bit_tick), 32'd0);
    check("rst_upd_pending", 32'(upd_pending), 32'd0);
    run(950, 1'b1);
    check("n_intervals", 32'(intervals.size() >= 17), 32'd1);
    if (intervals.size() >= 17) begin
      for (int i = 0; i < 9; i++) check("default_interval", 32'(intervals[i]), 32'(exp_iv[i]));
      sum = 0;
      for (int i = 1; i <= 16; i++) sum += intervals[i];
`ifdef BAUD_FRAC_EN
      check("sum16", 32'(sum), 32'd868);
`else
      check("sum16", 32'(sum), 32'd864);
`endif
    end

    // Divisor 2 written at cycle 10, applied at the first boundary
    do_reset();
    run(9, 1'b1);
    cyc(0, 1, 1, 2, 0);
    check("pend_after_wr", 32'(upd_pending), 32'd1);
    run(43, 1'b1);
    check("pend_before_bnd", 32'(upd_pending), 32'd1);
    run(1, 1'b1);
    check("pend_cleared", 32'(upd_pending), 32'd0);
    check("first_tick_at_54", 32'(last_tick), 32'd54);
    run(100, 1'b1);
    check_last_interval("div2_interval", 2);

    // Clamp of zero, then overwrite 326 by 651 before apply
    do_reset();
    run(5, 1'b1);
    cyc(0, 1, 1, 0, 0);
    run(60, 1'b1);
    check_last_interval("clamp_interval", 2);
    cyc(0, 1, 1, 326, 0);
    cyc(0, 1, 1, 651, 0);
    run(1400, 1'b1);
    check_last_interval("overwrite_interval", 651);

    // Hold en low mid-interval with a divisor write that applies at once
    do_reset();
    run(30, 1'b1);
    run(4, 1'b0);
    cyc(0, 0, 1, 10, 0);
    cyc(0, 0, 0, 0, 0);
    check("hold_apply", 32'(upd_pending), 32'd0);
    run(14, 1'b0);
    cyc(0, 1, 0, 0, 0);
    check("resume_tick", 32'(tick), 32'd1);
    run(40, 1'b1);
    check_last_interval("hold_div10", 10);

    // Reset mid-interval while a write is pending
    do_reset();
    run(20, 1'b1);
    cyc(0, 1, 1, 100, 3);
    run(5, 1'b1);
    do_reset();
    check("mid_rst_tick", 32'(tick), 32'd0);
    check("mid_rst_pend", 32'(upd_pending), 32'd0);
    run(60, 1'b1);
    check("mid_rst_first", 32'(intervals.size() > 0 ? intervals[0] : 0), 32'd54);

    // Random traffic
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      bit r, e, w;
      int di, df;
      r  = ($urandom_range(0, 399) == 0);
      e  = ($urandom_range(0, 99) < 85);
      w  = ($urandom_range(0, 99) < 2);
      di = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 8));
      df = int'($urandom_range(0, 15));
      cyc(r, e, w, di, df);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
